// File: rtl/lamp_ctrl_deb.sv
// Multi-switch lamp controller: synchronised, debounced switches where every
// accepted flip toggles the lamp, with optional auto-off timer and master-off.
module lamp_ctrl_deb #(
    parameter int unsigned N_SW       = 3,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] S,
    input  logic            all_off,
    output logic            F,
    output logic [N_SW-1:0] sw_db,
    output logic            toggle,
    output logic            timeout
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [N_SW-1:0]         sync1_q;
    logic [N_SW-1:0]         sync2_q;
    logic [N_SW-1:0]         sw_db_q;
    logic [N_SW-1:0]         sw_db_d;
    logic [N_SW-1:0]         ev;
    logic [N_SW-1:0][CW-1:0] cnt_q;
    logic [N_SW-1:0][CW-1:0] cnt_d;
    logic                    p;

    logic          f_q;
    logic          f_d;
    logic          toggle_q;
    logic          toggle_d;
    logic          timeout_q;
    logic          timeout_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Two-flop synchroniser for the raw switch pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= S;
            sync2_q <= sync1_q;
        end
    end

    // Any match with the debounced level restarts the count, so glitches are dropped
    always_comb begin
        sw_db_d = sw_db_q;
        ev      = '0;
        cnt_d   = '0;
        for (int i = 0; i < N_SW; i++) begin
            if (sync2_q[i] != sw_db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    sw_db_d[i] = sync2_q[i];
                    ev[i]      = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Simultaneous accepted flips cancel pairwise
    assign p = ^ev;

    always_comb begin
        f_d       = f_q;
        timer_d   = '0;
        toggle_d  = 1'b0;
        timeout_d = 1'b0;
        if (all_off) begin
            f_d = 1'b0;
        end else if (p) begin
            f_d      = ~f_q;
            toggle_d = 1'b1;
        end else if ((TIMEOUT != 0) && f_q) begin
            if (timer_q == TMR_LAST) begin
                f_d       = 1'b0;
                timeout_d = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_db_q   <= '0;
            cnt_q     <= '0;
            f_q       <= 1'b0;
            timer_q   <= '0;
            toggle_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sw_db_q   <= sw_db_d;
            cnt_q     <= cnt_d;
            f_q       <= f_d;
            timer_q   <= timer_d;
            toggle_q  <= toggle_d;
            timeout_q <= timeout_d;
        end
    end

    assign F       = f_q;
    assign sw_db   = sw_db_q;
    assign toggle  = toggle_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_lamp_ctrl_deb.sv
// Scoreboard bench for lamp_ctrl_deb: a window-based reference model predicts
// every cycle's outputs; a separate monitor pops and compares.
module tb_lamp_ctrl_deb;

    localparam int N = 3;
    localparam int D = 4;
    localparam int T = 20;

    typedef struct packed {
        logic         f;
        logic [N-1:0] db;
        logic         tg;
        logic         to;
    } out_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] s_drv = '0;
    logic         all_off_drv = 1'b0;
    logic         F;
    logic [N-1:0] sw_db;
    logic         toggle;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    out_t         exp_q[$];
    out_t         mon_e;
    out_t         mon_a;

    logic [N-1:0] hist[$];
    logic [N-1:0] m_db;
    logic         m_f;
    int           m_n;
    int           m_last;

    lamp_ctrl_deb #(
        .N_SW      (N),
        .DEB_CYCLES(D),
        .TIMEOUT   (T)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .S      (s_drv),
        .all_off(all_off_drv),
        .F      (F),
        .sw_db  (sw_db),
        .toggle (toggle),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Model: a level is accepted once the switch, as sampled two edges earlier,
    // has differed from the debounced level for the last D samples.
    always @(posedge clk or negedge rst_n) begin : model
        logic [N-1:0] ev;
        logic         all_diff;
        logic         tg;
        logic         to;
        if (!rst_n) begin
            hist.delete();
            for (int k = 0; k < D + 2; k++) hist.push_back('0);
            m_db   = '0;
            m_f    = 1'b0;
            m_n    = 0;
            m_last = 0;
            exp_q.delete();
        end else begin
            hist.push_back(s_drv);
            void'(hist.pop_front());
            ev = '0;
            for (int i = 0; i < N; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++)
                    if (hist[D-1-j][i] == m_db[i]) all_diff = 1'b0;
                ev[i] = all_diff;
            end
            m_n++;
            tg = 1'b0;
            to = 1'b0;
            if (all_off_drv) begin
                m_f = 1'b0;
            end else if (^ev) begin
                m_f    = ~m_f;
                tg     = 1'b1;
                m_last = m_n;
            end else if (T != 0 && m_f && (m_n - m_last) == T) begin
                m_f = 1'b0;
                to  = 1'b1;
            end
            m_db = m_db ^ ev;
            exp_q.push_back('{f: m_f, db: m_db, tg: tg, to: to});
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = '{f: F, db: sw_db, tg: toggle, to: timeout};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL outputs t=%0t got F=%b db=%b tg=%b to=%b exp F=%b db=%b tg=%b to=%b",
                         $time, mon_a.f, mon_a.db, mon_a.tg, mon_a.to,
                         mon_e.f, mon_e.db, mon_e.tg, mon_e.to);
            end
        end
    end

    task automatic hold(input logic [N-1:0] s, input logic ao, input int n);
        @(negedge clk);
        s_drv       = s;
        all_off_drv = ao;
        repeat (n) @(posedge clk);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({F, sw_db, toggle, timeout} !== '0) begin
            errors++;
            $display("FAIL %s got F=%b db=%b tg=%b to=%b exp all 0",
                     name, F, sw_db, toggle, timeout);
        end
    endtask

    task automatic reset_pulse(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [N-1:0] sweep[8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (sweep[k]) hold(sweep[k], 1'b0, 15);

        // Glitch shorter than the debounce window, then one just long enough
        hold(3'b000, 1'b0, 20);
        hold(3'b001, 1'b0, 3);
        hold(3'b000, 1'b0, 20);
        hold(3'b001, 1'b0, 5);
        hold(3'b000, 1'b0, 30);

        hold(3'b011, 1'b0, 20);
        hold(3'b000, 1'b0, 20);

        // Auto-off, then a re-flip 15 cycles after the rise
        hold(3'b100, 1'b0, 40);
        hold(3'b000, 1'b0, 15);
        hold(3'b100, 1'b0, 30);

        // all_off raised on the edge the flip is accepted
        hold(3'b000, 1'b0, 5);
        hold(3'b000, 1'b1, 3);
        hold(3'b000, 1'b0, 10);

        // Reset while debounce counters are mid-count
        hold(3'b001, 1'b0, 10);
        hold(3'b010, 1'b0, 4);
        reset_pulse(2);
        hold(3'b010, 1'b0, 20);

        for (int r = 0; r < 400; r++) begin
            hold(N'($urandom), ($urandom_range(0, 15) == 0), $urandom_range(1, 40));
            if ($urandom_range(0, 60) == 0) reset_pulse($urandom_range(1, 3));
        end

        hold(3'b000, 1'b0, 40);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
